// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: bus widths, handshake
// values, the FSM state encoding and a magnitude helper.
package div_unit_pkg;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Two's-complement magnitude; only negates when the operation is signed.
   // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
   function automatic logic [RegBus-1:0] mag(input logic [RegBus-1:0] v,
                                             input logic              sgn);
      return (sgn && v[RegBus-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   dividend_i : 65-bit working register {partial remainder, dividend/quotient bits, pad}
//   divisor_i  : divisor magnitude
//   dividend_o : working register after one quotient bit has been decided
module div_step
   import div_unit_pkg::*;
(
   input  logic [DoubleRegBus:0] dividend_i,
   input  logic [RegBus-1:0]     divisor_i,
   output logic [DoubleRegBus:0] dividend_o
);

   logic [RegBus:0] t;

   // Bit 32 of t is the borrow: set when the shifted partial remainder is
   // smaller than the divisor, so the quotient bit is 0 and nothing is subtracted.
   assign t = {1'b0, dividend_i[63:32]} - {1'b0, divisor_i};

   always_comb begin
      if (t[RegBus]) dividend_o = {dividend_i[63:0], 1'b0};
      else           dividend_o = {t[31:0], dividend_i[31:0], 1'b1};
   end

endmodule

// File: rtl/div_unit.sv
// 32-bit DIV/DIVU unit, one quotient bit per cycle, for the execute stage.
//   clk, rst          : clock, asynchronous active-low reset
//   signed_div_i      : 1 = DIV, 0 = DIVU
//   opdata1_i/2_i     : dividend / divisor, sampled on an accepted start
//   start_i, annul_i  : request held until ready_o; flush abort
//   result_o          : {remainder, quotient}
//   ready_o           : result valid
// Build option: DIV_EARLY_OUT_EN finishes in one cycle when |op1| < |op2|.
module div_unit
   import div_unit_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    signed_div_i,
   input  logic [RegBus-1:0]       opdata1_i,
   input  logic [RegBus-1:0]       opdata2_i,
   input  logic                    start_i,
   input  logic                    annul_i,
   output logic [DoubleRegBus-1:0] result_o,
   output logic                    ready_o
);

   div_state_e              state_q, state_d;
   logic [5:0]              cnt_q, cnt_d;
   logic [DoubleRegBus:0]   dividend_q, dividend_d;
   logic [RegBus-1:0]       divisor_q, divisor_d;
   logic                    neg1_q, neg1_d;   // signed op and dividend negative
   logic                    neg2_q, neg2_d;   // signed op and divisor negative
   logic [DoubleRegBus-1:0] result_q, result_d;
   logic                    ready_q, ready_d;

   logic [RegBus-1:0]       mag1, mag2, quo_fix, rem_fix;
   logic [DoubleRegBus:0]   step_out;

   assign mag1 = mag(opdata1_i, signed_div_i);
   assign mag2 = mag(opdata2_i, signed_div_i);

   // Truncating division: quotient sign is the xor of operand signs,
   // remainder follows the dividend.
   assign quo_fix = (neg1_q ^ neg2_q) ? -dividend_q[31:0]  : dividend_q[31:0];
   assign rem_fix = neg1_q            ? -dividend_q[64:33] : dividend_q[64:33];

   div_step u_step (
      .dividend_i (dividend_q),
      .divisor_i  (divisor_q),
      .dividend_o (step_out)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      neg1_d     = neg1_q;
      neg2_d     = neg2_q;
      result_d   = result_q;
      ready_d    = ready_q;
      case (state_q)
         DivFree: begin
            if (start_i == DivStart && !annul_i) begin
               neg1_d    = signed_div_i & opdata1_i[31];
               neg2_d    = signed_div_i & opdata2_i[31];
               divisor_d = mag2;
               cnt_d     = 6'd0;
               if (opdata2_i == '0) begin
                  state_d = DivByZero;
               end
`ifdef DIV_EARLY_OUT_EN
               else if (mag1 < mag2) begin
                  // Quotient 0, remainder is the raw dividend (sign kept).
                  dividend_d = {opdata1_i, 1'b0, 32'h0};
                  result_d   = {opdata1_i, 32'h0};
                  ready_d    = DivResultReady;
                  state_d    = DivEnd;
               end
`endif
               else begin
                  dividend_d = {32'h0, mag1, 1'b0};
                  state_d    = DivOn;
               end
            end
         end
         DivByZero: begin
            if (annul_i) begin
               state_d  = DivFree;
               result_d = '0;
               ready_d  = DivResultNotReady;
            end else begin
               dividend_d = '0;
               state_d    = DivEnd;
            end
         end
         DivOn: begin
            if (annul_i) begin
               state_d  = DivFree;
               cnt_d    = 6'd0;
               result_d = '0;
               ready_d  = DivResultNotReady;
            end else if (cnt_q != 6'd32) begin
               dividend_d = step_out;
               cnt_d      = cnt_q + 6'd1;
            end else begin
               // Keep the fixed-up result in the working register so DivEnd
               // can keep presenting it.
               dividend_d = {rem_fix, 1'b0, quo_fix};
               result_d   = {rem_fix, quo_fix};
               ready_d    = DivResultReady;
               cnt_d      = 6'd0;
               state_d    = DivEnd;
            end
         end
         DivEnd: begin
            if (annul_i || start_i == DivStop) begin
               state_d  = DivFree;
               result_d = '0;
               ready_d  = DivResultNotReady;
            end else begin
               result_d = {dividend_q[64:33], dividend_q[31:0]};
               ready_d  = DivResultReady;
            end
         end
         default: state_d = DivFree;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= DivFree;
         cnt_q      <= 6'd0;
         dividend_q <= '0;
         divisor_q  <= '0;
         neg1_q     <= 1'b0;
         neg2_q     <= 1'b0;
         result_q   <= '0;
         ready_q    <= DivResultNotReady;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         neg1_q     <= neg1_d;
         neg2_q     <= neg2_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule
